// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the rvga fetch stage.
package fetch_stage_pkg;

   typedef logic [31:0] rvga_word;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2,
      FS_DROP = 2'd3
   } rvga_fetch_state_e;

   localparam rvga_word RVGA_NOP = 32'h0000_0013;
   localparam rvga_word PC_STEP  = 32'h0000_0004;

   function automatic rvga_word align_word(input rvga_word addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic     imem_req_v_o;
   rvga_word imem_addr_o;
   logic     imem_req_ready_i;
   logic     imem_resp_v_i;
   rvga_word imem_resp_data_i;

   modport master (
      output imem_req_v_o,
      output imem_addr_o,
      input  imem_req_ready_i,
      input  imem_resp_v_i,
      input  imem_resp_data_i
   );

   modport slave (
      input  imem_req_v_o,
      input  imem_addr_o,
      output imem_req_ready_i,
      output imem_resp_v_i,
      output imem_resp_data_i
   );

endinterface

// File: rtl/dff.sv
// Enabled register with asynchronous active-low clear to a parameterised value.
module dff #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Storage element; holds when not enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_ctl.sv
// Fetch control FSM: sequences requests and drives the datapath enables.
module fetch_ctl
   import fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_s,
   input  logic              flush_s,
   input  logic              req_ready_s,
   input  logic              resp_v_s,
   output rvga_fetch_state_e state_r,
   output logic              pc_load_s,
   output logic              pc_redirect_s,
   output logic              out_load_s,
   output logic              out_from_hold_s,
   output logic              out_bubble_s,
   output logic              hold_we_s
);

   // State register; flush wins over stall and any response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FS_REQ;
      end else begin
         case (state_r)
            FS_REQ: begin
               if (req_ready_s) begin
                  state_r <= flush_s ? FS_DROP : FS_WAIT;
               end else begin
                  state_r <= FS_REQ;
               end
            end
            FS_WAIT: begin
               if (flush_s) begin
                  state_r <= resp_v_s ? FS_REQ : FS_DROP;
               end else if (resp_v_s) begin
                  state_r <= stall_s ? FS_HOLD : FS_REQ;
               end else begin
                  state_r <= FS_WAIT;
               end
            end
            FS_HOLD: begin
               if (flush_s || !stall_s) begin
                  state_r <= FS_REQ;
               end else begin
                  state_r <= FS_HOLD;
               end
            end
            FS_DROP: begin
               state_r <= resp_v_s ? FS_REQ : FS_DROP;
            end
            default: begin
               state_r <= FS_REQ;
            end
         endcase
      end
   end

   // Datapath enables decoded from the current state and this cycle's inputs.
   always_comb begin
      pc_load_s       = 1'b0;
      pc_redirect_s   = 1'b0;
      out_load_s      = 1'b0;
      out_from_hold_s = 1'b0;
      hold_we_s       = 1'b0;
      if (flush_s) begin
         pc_load_s     = 1'b1;
         pc_redirect_s = 1'b1;
      end else begin
         case (state_r)
            FS_WAIT: begin
               if (resp_v_s && !stall_s) begin
                  out_load_s = 1'b1;
                  pc_load_s  = 1'b1;
               end else if (resp_v_s) begin
                  hold_we_s = 1'b1;
               end else begin
                  hold_we_s = 1'b0;
               end
            end
            FS_HOLD: begin
               if (!stall_s) begin
                  out_load_s      = 1'b1;
                  out_from_hold_s = 1'b1;
                  pc_load_s       = 1'b1;
               end else begin
                  out_load_s = 1'b0;
               end
            end
            default: begin
               out_load_s = 1'b0;
            end
         endcase
      end
      out_bubble_s = flush_s | (!stall_s & !out_load_s);
   end

   fetch_ctl_chk u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .state_r  (state_r),
      .resp_v_s (resp_v_s)
   );

endmodule

// File: rtl/fetch_ctl_chk.sv
// Protocol checker for the fetch control FSM.
module fetch_ctl_chk
   import fetch_stage_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   input rvga_fetch_state_e state_r,
   input logic              resp_v_s
);

   // A response while no request is outstanding is a memory protocol error.
   resp_in_req_a: assert property (@(posedge clk) disable iff (!rst_n)
      !((state_r == FS_REQ) && resp_v_s));

endmodule

// File: rtl/mux.sv
// Two-input word multiplexer.
module mux #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] y
);

   // Select in1 when sel is high.
   always_comb begin
      if (sel) begin
         y = in1;
      end else begin
         y = in0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rvga instruction fetch stage: PC, hold buffer and registered decode-facing output.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter rvga_word reset_pc_p = 32'h0000_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_v_i,
   input  logic          flush_v_i,
   input  rvga_word      redirect_pc_i,
   fetch_stage_if.master imem,
   output rvga_word      pc_o,
   output rvga_word      ir_o,
   output logic          v_o
);

   rvga_fetch_state_e state_s;
   logic              pc_load_s;
   logic              pc_redirect_s;
   logic              out_load_s;
   logic              out_from_hold_s;
   logic              out_bubble_s;
   logic              hold_we_s;
   logic              out_en_s;
   rvga_word          pc_r;
   rvga_word          hold_ir_r;
   rvga_word          pc_inc_s;
   rvga_word          pc_redir_s;
   rvga_word          pc_nxt_s;
   rvga_word          ir_src_s;
   rvga_word          ir_nxt_s;

   fetch_ctl u_ctl (
      .clk             (clk_i),
      .rst_n           (rst_i),
      .stall_s         (stall_v_i),
      .flush_s         (flush_v_i),
      .req_ready_s     (imem.imem_req_ready_i),
      .resp_v_s        (imem.imem_resp_v_i),
      .state_r         (state_s),
      .pc_load_s       (pc_load_s),
      .pc_redirect_s   (pc_redirect_s),
      .out_load_s      (out_load_s),
      .out_from_hold_s (out_from_hold_s),
      .out_bubble_s    (out_bubble_s),
      .hold_we_s       (hold_we_s)
   );

   assign pc_inc_s   = pc_r + PC_STEP;
   assign pc_redir_s = align_word(redirect_pc_i);

   mux #(.WIDTH(32)) u_pc_mux (
      .sel (pc_redirect_s),
      .in0 (pc_inc_s),
      .in1 (pc_redir_s),
      .y   (pc_nxt_s)
   );

   dff #(.WIDTH(32), .RESET_VAL(reset_pc_p)) u_pc (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (pc_load_s),
      .d     (pc_nxt_s),
      .q     (pc_r)
   );

   dff #(.WIDTH(32), .RESET_VAL(32'h0000_0000)) u_hold_ir (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (hold_we_s),
      .d     (imem.imem_resp_data_i),
      .q     (hold_ir_r)
   );

   // The held word is only used while leaving HOLD; otherwise take the live response.
   mux #(.WIDTH(32)) u_ir_src (
      .sel (out_from_hold_s),
      .in0 (imem.imem_resp_data_i),
      .in1 (hold_ir_r),
      .y   (ir_src_s)
   );

   mux #(.WIDTH(32)) u_ir_nxt (
      .sel (out_load_s),
      .in0 (RVGA_NOP),
      .in1 (ir_src_s),
      .y   (ir_nxt_s)
   );

   assign out_en_s = out_load_s | out_bubble_s;

   dff #(.WIDTH(32), .RESET_VAL(reset_pc_p)) u_pc_out (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (out_load_s),
      .d     (pc_r),
      .q     (pc_o)
   );

   dff #(.WIDTH(32), .RESET_VAL(RVGA_NOP)) u_ir_out (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (out_en_s),
      .d     (ir_nxt_s),
      .q     (ir_o)
   );

   dff #(.WIDTH(1), .RESET_VAL(1'b0)) u_v_out (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (out_en_s),
      .d     (out_load_s),
      .q     (v_o)
   );

   // Gated by reset so no request is presented while reset is held.
   assign imem.imem_req_v_o = rst_i & (state_s == FS_REQ);
   assign imem.imem_addr_o  = pc_r;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the rvga in-order pipeline. Holds the program counter and issues word requests to instruction memory over a valid/ready request channel with at most one outstanding response. Presents a registered `pc_o`/`ir_o`/`v_o` triple to the decode stage. Honors the same `stall_v_i`/`flush_v_i` pair that decode sees, plus a redirect target from execute.

## Interface
- `reset_pc_p`, default `32'h0000_0000`: PC fetched first after reset; bits [1:0] must be 0.
- `clk_i`, input, 1: clock; all state on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-low.
- `stall_v_i`, input, 1: decode cannot accept; fetch output register holds.
- `flush_v_i`, input, 1: redirect; squash the fetch output and any in-flight fetch.
- `redirect_pc_i`, input, 32 (`rvga_word`): new PC when `flush_v_i`=1; bits [1:0] forced to 0.
- `imem_req_v_o`, output, 1: request valid.
- `imem_addr_o`, output, 32: request word address (the PC).
- `imem_req_ready_i`, input, 1: memory accepts the request this cycle.
- `imem_resp_v_i`, input, 1: response valid, at most one per accepted request, in order.
- `imem_resp_data_i`, input, 32: instruction word.
- `pc_o`, output, 32: PC of `ir_o`.
- `ir_o`, output, 32: instruction to decode; `RVGA_NOP` (`32'h0000_0013`) when `v_o`=0.
- `v_o`, output, 1: `pc_o`/`ir_o` carry a real instruction.

## Operation
- Registers:
  - `pc_r`
  - FSM state
  - hold buffer (`hold_ir_r`)
  - output register (`pc_o`, `ir_o`, `v_o`)
- REQ state:
  - Drive `imem_req_v_o`=1 with `imem_addr_o`=`pc_r`.
  - Go to WAIT on `imem_req_ready_i`; otherwise stay in REQ with address stable.
- WAIT state, on `imem_resp_v_i`:
  - If `stall_v_i`=0: load the output register with `pc_r`, data and `v_o`=1; `pc_r`+=4; go to REQ.
  - If `stall_v_i`=1: capture data into `hold_ir_r`; go to HOLD.
- HOLD state:
  - While stalled, keep the output register and the buffer unchanged.
  - On the first unstalled cycle, load the output register from `hold_ir_r`/`pc_r`; `pc_r`+=4; go to REQ.
- DROP state: wait for the response of a squashed request, discard it, then go to REQ.
- Output register when not stalled and no instruction is loaded this cycle: bubble (`v_o`=0, `ir_o`=NOP, `pc_o` unchanged).
- When `stall_v_i`=1 and no flush: the output register holds all fields.
- `flush_v_i`=1 has priority over stall and over any response:
  - `pc_r` <= `redirect_pc_i`&~3; output register <= bubble; `hold_ir_r` discarded.
  - Next state from REQ: DROP if the request was accepted this same cycle, else REQ.
  - Next state from WAIT or DROP: REQ if `imem_resp_v_i`=1 this cycle (that response is discarded), else DROP.
  - Next state from HOLD: REQ.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC`+4 wraps to 0.
- A response in REQ state is a protocol error. It is ignored, and an assertion must flag it.

## Timing
- Reset values:
  - `pc_r` = `reset_pc_p`
  - state = REQ
  - `pc_o` = `reset_pc_p`
  - `ir_o` = NOP
  - `v_o` = 0
  - `hold_ir_r` = 0
- During reset `imem_req_v_o`=0. It is 1 in the first cycle after deassertion.
- `imem_req_v_o`, `imem_addr_o` and `v_o` are functions of registered state only; there is no combinational path from the `imem_*` inputs to them.
- Minimum latency:
  - Request accepted at edge N, response in cycle N+1, instruction visible on `pc_o`/`ir_o` after edge N+2.
  - Peak throughput is one instruction per 2 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. A response arriving after reset deassertion is discarded only if the memory also resets; the bench resets both together.

## Structure
- `rvga_types` gains:
  - `rvga_fetch_state_e` (REQ, WAIT, HOLD, DROP)
  - constant `RVGA_NOP`
- Split the control logic into sub-module `fetch_ctl`:
  - Inputs: stall, flush, `imem_req_ready_i`, `imem_resp_v_i`.
  - Outputs: state, PC-load select, output-register load/bubble enables, hold-buffer write enable.
- The PC, hold buffer and output register are instantiated in `fetch_stage` using the existing `dff` and `mux`.

## Test plan
- Reset, then 1-cycle-ready memory returning `addr^32'hA5A5_0000`:
  - `imem_addr_o` = 0, 4, 8.
  - `v_o` pulses every 2nd cycle with `pc_o` 0, 4, 8 and matching `ir_o`.
- Hold `imem_req_ready_i`=0 for 3 cycles:
  - `imem_req_v_o` stays 1 and the address stays 0.
  - No `v_o` until 2 cycles after ready rises.
- Assert `stall_v_i` for 4 cycles spanning a response for PC 8:
  - Output holds the PC 4 instruction.
  - After the stall, PC 8 appears exactly once; no request is issued while in HOLD.
- `flush_v_i` with `redirect_pc_i`=`32'h0000_0103` while in WAIT:
  - The next response is dropped and `v_o`=0 that cycle.
  - The next request has address `32'h100`.
  - The first valid output is `pc_o`=`32'h100`.
- Flush and response arrive in the same cycle, and separately flush while in HOLD:
  - No stale instruction ever reaches `v_o`=1.
- Set `reset_pc_p` = `32'hFFFF_FFFC`: the second fetch address is `32'h0000_0000`.
